// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply engine.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  // Ceiling log2, usable in constant expressions for widths.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single multiply-accumulate step. This block is combinational.
// The running sum restarts from zero when clear_i is high.
module matmul_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  parameter bit SIGNED = 1'b0
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [ACC_W-1:0]  acc_i,
  input  logic              clear_i,
  output logic [ACC_W-1:0]  acc_next_o
);

  localparam int PROD_W = 2 * DATA_W;

  logic [ACC_W-1:0] prod_ext;

  if (SIGNED) begin : g_signed
    logic signed [PROD_W-1:0] a_s;
    logic signed [PROD_W-1:0] b_s;
    logic signed [PROD_W-1:0] prod_s;
    assign a_s      = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    assign b_s      = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    assign prod_s   = a_s * b_s;
    assign prod_ext = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
  end else begin : g_unsigned
    logic [PROD_W-1:0] prod_u;
    assign prod_u   = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
    assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod_u};
  end

  assign acc_next_o = (clear_i ? '0 : acc_i) + prod_ext;

endmodule

// File: rtl/matmul_engine.sv
// N x N matrix multiplier. A and B stream in element by element.
// One MAC per cycle computes C = A x B.
// C then streams out byte-serially, least-significant byte of each result first.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N      = 3,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int ACC_W     = 2 * DATA_W + clog2(N);
  localparam int OUT_BYTES = (ACC_W + 7) / 8;
  localparam int OUT_W     = OUT_BYTES * 8;
  localparam int NN        = N * N;
  localparam int CNT_W     = clog2(N);
  localparam int IDX_W     = clog2(NN);
  localparam int BYTE_W    = (OUT_BYTES > 1) ? clog2(OUT_BYTES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NN - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(OUT_BYTES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  row_q, row_d, col_q, col_d, k_q, k_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] a_mem_q [NN];
  logic [DATA_W-1:0] b_mem_q [NN];
  logic [ACC_W-1:0]  c_mem_q [NN];

  logic              in_xfer, out_xfer;
  logic              last_idx, last_k, last_col, last_row, last_byte;
  logic [IDX_W-1:0]  a_rd_idx, b_rd_idx, c_wr_idx;
  logic [ACC_W-1:0]  acc_next;
  logic [OUT_W-1:0]  drain_word;

  // Widen a result to whole bytes: sign-extend in signed mode, zero-pad otherwise.
  function automatic logic [OUT_W-1:0] ext_result(input logic [ACC_W-1:0] value);
    logic [OUT_W-1:0] one;
    logic [OUT_W-1:0] ext;
    one = OUT_W'(1);
    ext = OUT_W'(value);
    if (SIGNED && value[ACC_W-1]) ext = ext | ~((one << ACC_W) - one);
    return ext;
  endfunction

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign last_idx  = (idx_q == IDX_LAST);
  assign last_k    = (k_q == CNT_LAST);
  assign last_col  = (col_q == CNT_LAST);
  assign last_row  = (row_q == CNT_LAST);
  assign last_byte = (byte_q == BYTE_LAST);
  assign a_rd_idx  = IDX_W'(int'(row_q) * N + int'(k_q));
  assign b_rd_idx  = IDX_W'(int'(k_q) * N + int'(col_q));
  assign c_wr_idx  = IDX_W'(int'(row_q) * N + int'(col_q));

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .a_i        (a_mem_q[a_rd_idx]),
    .b_i        (b_mem_q[b_rd_idx]),
    .acc_i      (acc_q),
    .clear_i    (k_q == '0),
    .acc_next_o (acc_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Abort overrides everything, including start in IDLE.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = LOAD_A;
        LOAD_A:  if (in_xfer && last_idx) state_d = LOAD_B;
        LOAD_B:  if (in_xfer && last_idx) state_d = COMPUTE;
        COMPUTE: if (last_k && last_col && last_row) state_d = DRAIN;
        DRAIN:   if (out_xfer && last_byte && last_idx) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake and status outputs are decoded from the state.
  // out_data is decoded from the counters, which stay frozen while the consumer stalls.
  always_comb begin
    in_ready   = (state_q == LOAD_A) || (state_q == LOAD_B);
    out_valid  = (state_q == DRAIN);
    busy       = (state_q != IDLE);
    done       = done_q;
    drain_word = ext_result(c_mem_q[idx_q]) >> {byte_q, 3'b000};
    out_data   = (state_q == DRAIN) ? drain_word[7:0] : 8'h00;
  end

  // Counter and accumulator updates. idx is shared between the load phases and the drain phase.
  always_comb begin
    idx_d  = idx_q;
    row_d  = row_q;
    col_d  = col_q;
    k_d    = k_q;
    byte_d = byte_q;
    acc_d  = acc_q;
    done_d = 1'b0;
    if (abort) begin
      idx_d  = '0;
      row_d  = '0;
      col_d  = '0;
      k_d    = '0;
      byte_d = '0;
      acc_d  = '0;
    end else begin
      unique case (state_q)
        LOAD_A, LOAD_B: begin
          if (in_xfer) idx_d = last_idx ? '0 : idx_q + 1'b1;
        end
        COMPUTE: begin
          acc_d = acc_next;
          k_d   = last_k ? '0 : k_q + 1'b1;
          if (last_k) begin
            col_d = last_col ? '0 : col_q + 1'b1;
            if (last_col) row_d = last_row ? '0 : row_q + 1'b1;
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            byte_d = last_byte ? '0 : byte_q + 1'b1;
            if (last_byte) begin
              idx_d  = last_idx ? '0 : idx_q + 1'b1;
              done_d = last_idx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
      k_q    <= '0;
      byte_q <= '0;
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      row_q  <= row_d;
      col_q  <= col_d;
      k_q    <= k_d;
      byte_q <= byte_d;
      acc_q  <= acc_d;
      done_q <= done_d;
    end
  end

  // Operand and result storage. Reset does not touch these arrays.
  // C[row][col] is written on the final k step of its dot product.
  always_ff @(posedge clk) begin
    if (in_xfer && !abort && state_q == LOAD_A) a_mem_q[idx_q] <= in_data;
    if (in_xfer && !abort && state_q == LOAD_B) b_mem_q[idx_q] <= in_data;
    if (!abort && state_q == COMPUTE && last_k) c_mem_q[c_wr_idx] <= acc_next;
  end

endmodule
